// File: rtl/bw_pkg.sv
// Shared definitions for the sequential Baugh-Wooley multiplier.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
// Contents: FSM state enum and its encoding width, and bw_corr(), the
// accumulator preload that makes the inverted-row sum equal the signed product.
package bw_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bw_state_t;

  // Baugh-Wooley correction: 2^width + 2^(2*width-1).
  // Returned in 64 bits, which covers every width up to 32.
  function automatic logic [63:0] bw_corr(input int width);
    logic [63:0] c;
    c = (64'd1 << width) | (64'd1 << (2 * width - 1));
    return c;
  endfunction

endpackage

// File: rtl/bw_pp_row.sv
// One partial-product row of a Baugh-Wooley multiplier (AND / NAND cells).
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
// Ports: a (multiplicand), b_bit (the multiplier bit for this row),
//        signed_mode, is_last_row (row index is WIDTH-1), row (output bits).
module bw_pp_row
  import bw_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic             b_bit,
  input  logic             signed_mode,
  input  logic             is_last_row,
  output logic [WIDTH-1:0] row
);

  // In signed mode the cell becomes a NAND when exactly one of "top column"
  // and "last row" holds; the sign-bit x sign-bit cell stays a plain AND.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    localparam logic TOP_COL = (i == WIDTH - 1);
    assign row[i] = (a[i] & b_bit) ^ (signed_mode & (TOP_COL ^ is_last_row));
  end

endmodule

// File: rtl/bw_seq_multiplier.sv
// Sequential Baugh-Wooley multiplier: one partial-product row retired per clock.
// Latency: WIDTH+1 cycles from start acceptance to the done pulse.
// Backpressure: start is ignored while busy; accepted again the cycle after done.
// Ports: clk, rst (sync, active high), start, signed_mode, a, b (sampled with start),
//        busy, done (one-cycle pulse), product (2*WIDTH, held until the next done).
// WIDTH is limited to 2..32 by the 64-bit correction constant.
module bw_seq_multiplier
  import bw_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [PW-1:0]    CORR     = PW'(bw_corr(WIDTH));
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(WIDTH - 1);

  bw_state_t        state;
  bw_state_t        state_next;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             mode_q;
  logic [PW-1:0]    acc;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] row;
  logic [PW-1:0]    acc_sum;
  logic             last_row;

  assign last_row = (cnt == LAST_ROW);

  bw_pp_row #(
    .WIDTH(WIDTH)
  ) u_row (
    .a           (a_q),
    .b_bit       (b_q[cnt]),
    .signed_mode (mode_q),
    .is_last_row (last_row),
    .row         (row)
  );

  // Row j carries weight 2^j; carries past bit PW-1 are dropped (mod 2^PW).
  assign acc_sum = acc + (PW'(row) << cnt);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_row) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            mode_q <= signed_mode;
            acc    <= signed_mode ? CORR : '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          acc <= acc_sum;
          if (last_row) begin
            cnt     <= '0;
            // Publish on the edge into DONE so the result is visible
            // in the same cycle that done is high.
            product <= acc_sum;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
